led_pattern_gen: RTL and testbench

- Parametrised multi-channel LED driver; successor to the free-running single-counter LED blinker.
- Each channel runs independently in one of four modes: OFF, ON, BLINK or BREATHE (PWM triangle fade).
- Rate is set per channel at runtime through a single-cycle config write port.
- Sits between a shared board clock and the board's RGB/user LED pins, giving rate control instead of fixed counter-bit taps.

---
 rtl/led_pattern_gen.sv | 100 ++++++++++
 tb/tb_led_pattern_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with per-channel OFF/ON/BLINK/BREATHE modes
module led_pattern_gen #(
  parameter int NUM_CH = 3,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 27000,
  parameter int RATE_BITS = 10,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [RATE_BITS-1:0] cfg_rate,
  output logic [NUM_CH-1:0]    led,
  output logic                 tick
);
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_e;
  logic [PS_W-1:0] presc_q, presc_d;
  logic tick_q;
  logic [PWM_BITS-1:0] pwm_q;
  mode_e mode_q [NUM_CH];
  mode_e mode_d [NUM_CH];
  logic [RATE_BITS-1:0] rate_q [NUM_CH];
  logic [RATE_BITS-1:0] rate_d [NUM_CH];
  logic [RATE_BITS-1:0] step_q [NUM_CH];
  logic [RATE_BITS-1:0] step_d [NUM_CH];
  logic [PWM_BITS-1:0] phase_q [NUM_CH];
  logic [PWM_BITS-1:0] phase_d [NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d, blink_q, blink_d, raw, led_q;
  assign led = led_q;
  assign tick = tick_q;
  // A config write to a channel overrides any step that would coincide with it
  always_comb begin
    presc_d = presc_q == PS_W'(PRESCALE-1) ? '0 : presc_q + 1'b1;
    mode_d = mode_q;
    rate_d = rate_q;
    step_d = step_q;
    phase_d = phase_q;
    dir_d = dir_q;
    blink_d = blink_q;
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        mode_d[i] = mode_e'(cfg_mode);
        rate_d[i] = cfg_rate;
        step_d[i] = '0;
        phase_d[i] = '0;
        dir_d[i] = 1'b0;
        blink_d[i] = 1'b0;
      end else if (tick_q) begin
        step_d[i] = step_q[i] == rate_q[i] ? '0 : step_q[i] + 1'b1;
        if (step_q[i] == rate_q[i] && mode_q[i] == M_BLINK)
          blink_d[i] = ~blink_q[i];
        if (step_q[i] == rate_q[i] && mode_q[i] == M_BREATHE) begin
          if (!dir_q[i]) begin
            phase_d[i] = phase_q[i] == MAX ? MAX - 1'b1 : phase_q[i] + 1'b1;
            dir_d[i] = phase_q[i] == MAX;
          end else begin
            phase_d[i] = phase_q[i] == '0 ? PWM_BITS'(1) : phase_q[i] - 1'b1;
            dir_d[i] = phase_q[i] != '0;
          end
        end
      end
      raw[i] = mode_q[i] == M_ON ? 1'b1 :
               mode_q[i] == M_BLINK ? blink_q[i] :
               mode_q[i] == M_BREATHE ? (pwm_q < phase_q[i]) : 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q <= 1'b0;
      pwm_q <= '0;
      dir_q <= '0;
      blink_q <= '0;
      led_q <= {NUM_CH{ACTIVE_LOW}};
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= M_OFF;
        rate_q[i] <= '0;
        step_q[i] <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      tick_q <= presc_q == PS_W'(PRESCALE-1);
      pwm_q <= pwm_q + 1'b1;
      mode_q <= mode_d;
      rate_q <= rate_d;
      step_q <= step_d;
      phase_q <= phase_d;
      dir_q <= dir_d;
      blink_q <= blink_d;
      led_q <= raw ^ {NUM_CH{ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen in active-high and active-low builds
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_rate = '0;
  logic [2:0] led_a, led_b;
  logic tick, tick_b;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_CH(3), .PWM_BITS(4), .PRESCALE(4), .RATE_BITS(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_rate(cfg_rate), .led(led_a), .tick(tick));
  led_pattern_gen #(.NUM_CH(3), .PWM_BITS(4), .PRESCALE(4), .RATE_BITS(4), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_rate(cfg_rate), .led(led_b), .tick(tick_b));

  // Drives a one-cycle write starting now (called just after a negedge).
  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] rate);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_mode = mode;
    cfg_rate = rate;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns at the negedge where tick is seen; the following posedge is a step edge.
  task automatic wait_tick;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 16);
    if (!tick) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, expected 1", tick, n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL reset_led: got %b expected 000", led_a); end
    vectors++;
    if (led_b !== 3'b111) begin miscompares++; $display("FAIL reset_led_al: got %b expected 111", led_b); end
    vectors++;
    if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", tick); end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if (tick !== (k % 4 == 0)) begin
        miscompares++;
        $display("FAIL tick_k%0d: got %b expected %b", k, tick, k % 4 == 0);
      end
    end
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL idle_led: got %b expected 000", led_a); end
  endtask

  task automatic test_on_off;
    wr(2'd1, 2'd1, 4'd0);
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL on_latency: got %b expected 000", led_a); end
    @(negedge clk);
    vectors++;
    if (led_a !== 3'b010) begin miscompares++; $display("FAIL on: got %b expected 010", led_a); end
    vectors++;
    if (led_b !== 3'b101) begin miscompares++; $display("FAIL on_al: got %b expected 101", led_b); end
    wr(2'd1, 2'd0, 4'd0);
    vectors++;
    if (led_a !== 3'b010) begin miscompares++; $display("FAIL off_latency: got %b expected 010", led_a); end
    @(negedge clk);
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL off: got %b expected 000", led_a); end
  endtask

  // Blink write lands one edge after a step edge; led[0] then high for k in [12,24), [36,48)...
  task automatic blink_run(input int n, input string tag);
    logic [2:0] exp_led;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      exp_led = {2'b00, (k / 12) % 2 == 1};
      vectors++;
      if (led_a !== exp_led) begin
        miscompares++;
        $display("FAIL %s_k%0d: got %b expected %b", tag, k, led_a, exp_led);
      end
    end
  endtask

  task automatic test_blink;
    wait_tick;
    @(negedge clk);
    wr(2'd0, 2'd2, 4'd2);
    blink_run(14, "blink");
    wait_tick;
    @(negedge clk);
    wr(2'd0, 2'd2, 4'd2);
    blink_run(30, "blink_rewrite");
  endtask

  // rate=15 holds each phase for 64 cycles, so lit count per window is 4*phase.
  task automatic test_breathe;
    int cnt, ph;
    wr(2'd0, 2'd0, 4'd0);
    wait_tick;
    @(negedge clk);
    wr(2'd2, 2'd3, 4'd15);
    for (int m = 0; m < 34; m++) begin
      ph = m <= 15 ? m : (m <= 30 ? 30 - m : m - 30);
      cnt = 0;
      for (int c = 0; c < 64; c++) begin
        cnt += int'(led_a[2]);
        @(negedge clk);
      end
      vectors++;
      if (cnt !== 4 * ph) begin
        miscompares++;
        $display("FAIL breathe_m%0d: got %0d lit cycles expected %0d", m, cnt, 4 * ph);
      end
    end
  endtask

  task automatic test_collision;
    logic e0, e1;
    wr(2'd2, 2'd0, 4'd0);
    wait_tick;
    @(negedge clk);
    wr(2'd1, 2'd2, 4'd1);
    wait_tick;
    wr(2'd0, 2'd2, 4'd1);
    for (int k = 1; k <= 40; k++) begin
      cfg_we = (k == 10);
      cfg_ch = 2'd3;
      cfg_mode = 2'd1;
      cfg_rate = 4'd0;
      @(negedge clk);
      e1 = k >= 5 && ((k - 5) % 16) < 8;
      e0 = k >= 9 && ((k - 9) % 16) < 8;
      vectors++;
      if (led_a !== {1'b0, e1, e0}) begin
        miscompares++;
        $display("FAIL collide_k%0d: got %b expected %b", k, led_a, {1'b0, e1, e0});
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_async_reset;
    wr(2'd2, 2'd3, 4'd0);
    wr(2'd0, 2'd1, 4'd0);
    repeat (5) @(negedge clk);
    vectors++;
    if (led_b[0] !== 1'b0) begin miscompares++; $display("FAIL al_on: got %b expected 0", led_b[0]); end
    vectors++;
    if (led_a[0] !== 1'b1) begin miscompares++; $display("FAIL ah_on: got %b expected 1", led_a[0]); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (led_b !== 3'b111) begin miscompares++; $display("FAIL async_al: got %b expected 111", led_b); end
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL async_ah: got %b expected 000", led_a); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (led_a !== 3'b000) begin miscompares++; $display("FAIL cfg_lost: got %b expected 000", led_a); end
    vectors++;
    if (led_b !== 3'b111) begin miscompares++; $display("FAIL cfg_lost_al: got %b expected 111", led_b); end
  endtask

  initial begin
    test_reset;
    test_on_off;
    test_blink;
    test_breathe;
    test_collision;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
